// File: rtl/text_screen_scheduler_if.sv
// Host-side bundle of the text screen scheduler: character write handshake and clear control.
interface text_screen_scheduler_if #(
  parameter int CHAR_W = 6
);
  logic              wr_valid;
  logic              wr_ready;
  logic [6:0]        wr_col;
  logic [5:0]        wr_row;
  logic [CHAR_W-1:0] wr_char;
  logic              wr_err;
  logic              clr_req;
  logic              clr_busy;

  modport master (
    output wr_valid, wr_col, wr_row, wr_char, clr_req,
    input  wr_ready, wr_err, clr_busy
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_char, clr_req,
    output wr_ready, wr_err, clr_busy
  );
endinterface

// File: rtl/text_screen_scheduler.sv
// Character-code buffer for the LCD text display: one single-port RAM shared by display
// fetches (highest priority), host writes and a full-screen clear sweep.
module text_screen_scheduler #(
  parameter int                COLS       = 100,
  parameter int                ROWS       = 60,
  parameter int                CHAR_W     = 6,
  parameter logic [CHAR_W-1:0] CLEAR_CHAR = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [10:0]             col_in,
  input  logic [9:0]              fila_in,
  input  logic                    den_in,
  text_screen_scheduler_if.slave  host,
  output logic [CHAR_W-1:0]       char_code,
  output logic                    char_valid
);
  localparam int                CELLS     = COLS * ROWS;
  localparam int                ADDR_W    = $clog2(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nxt;
  logic [CHAR_W-1:0] r_mem [CELLS];
  logic [CHAR_W-1:0] r_rd_data;
  logic              r_slot_d1, r_hit_d1;
  logic              r_wr_err;
  logic [CHAR_W-1:0] r_char_code;
  logic              r_char_valid;

  logic [7:0]        w_cc;
  logic [6:0]        w_rr;
  logic              w_slot, w_hit, w_wr_in_range, w_accept, w_we;
  logic [ADDR_W-1:0] w_fetch_addr, w_host_addr, w_waddr, w_addr;
  logic [CHAR_W-1:0] w_wdata;
  logic              w_unused;

  assign w_cc     = col_in[10:3];
  assign w_rr     = fila_in[9:3];
  assign w_unused = &{1'b0, fila_in[2:0]};

  // A fetch slot is the first pixel of each visible 8-pixel cell; every other cycle is free.
  assign w_slot        = den_in && (col_in[2:0] == 3'd0);
  assign w_hit         = w_slot && (int'(w_cc) < COLS) && (int'(w_rr) < ROWS);
  assign w_fetch_addr  = ADDR_W'(int'(w_rr) * COLS + int'(w_cc));
  assign w_wr_in_range = (int'(host.wr_col) < COLS) && (int'(host.wr_row) < ROWS);
  assign w_host_addr   = ADDR_W'(int'(host.wr_row) * COLS + int'(host.wr_col));

  assign host.wr_ready = (r_state == S_IDLE) && !w_slot && !RST;
  assign w_accept      = host.wr_valid && host.wr_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_we           = 1'b0;
    w_waddr        = r_clr_addr;
    w_wdata        = CLEAR_CHAR;
    case (r_state)
      S_CLEAR: begin
        if (!w_slot) begin
          w_we = 1'b1;
          if (r_clr_addr == LAST_ADDR) begin
            w_clr_addr_nxt = '0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
          end
        end
      end
      S_IDLE: begin
        if (w_accept && w_wr_in_range) begin
          w_we    = 1'b1;
          w_waddr = w_host_addr;
          w_wdata = host.wr_char;
        end
        // A coincident write still lands; the sweep that starts next overwrites it.
        if (host.clr_req) begin
          w_state_nxt    = S_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Writes only happen in free cycles and reads only in slots, so one port suffices.
  assign w_addr = w_we ? w_waddr : w_fetch_addr;

  // NOTE: the buffer array is deliberately not reset; the clear sweep initialises it and a
  // reset term would keep it from mapping onto block RAM.
  always_ff @(posedge CLK) begin
    if (w_we && !RST) r_mem[w_addr] <= w_wdata;
    if (w_hit)        r_rd_data     <= r_mem[w_addr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_CLEAR;
      r_clr_addr   <= '0;
      r_wr_err     <= 1'b0;
      r_slot_d1    <= 1'b0;
      r_hit_d1     <= 1'b0;
      r_char_code  <= CLEAR_CHAR;
      r_char_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_wr_err   <= w_accept && !w_wr_in_range;
      r_slot_d1  <= w_slot;
      r_hit_d1   <= w_hit;
      if (r_slot_d1) begin
        r_char_code  <= r_hit_d1 ? r_rd_data : CLEAR_CHAR;
        r_char_valid <= r_hit_d1;
      end
    end
  end

  assign host.wr_err   = r_wr_err;
  assign host.clr_busy = (r_state == S_CLEAR);
  assign char_code     = r_char_code;
  assign char_valid    = r_char_valid;
endmodule

// File: tb/tb_text_screen_scheduler.sv
// Directed bench for text_screen_scheduler: fetch vector table plus hand-written sequences for
// reset/clear duration, write stalls, out-of-range writes, clear during video and mid-sweep reset.
module tb_text_screen_scheduler;
  localparam int CHAR_W = 6;
  localparam int CELLS  = 6000;

  logic              CLK = 1'b0;
  logic              RST;
  logic [10:0]       col_in;
  logic [9:0]        fila_in;
  logic              den_in;
  logic [CHAR_W-1:0] char_code;
  logic              char_valid;

  text_screen_scheduler_if #(.CHAR_W(CHAR_W)) host_if ();

  text_screen_scheduler #(
    .COLS(100), .ROWS(60), .CHAR_W(CHAR_W), .CLEAR_CHAR(6'o00)
  ) dut (
    .CLK(CLK), .RST(RST), .col_in(col_in), .fila_in(fila_in), .den_in(den_in),
    .host(host_if), .char_code(char_code), .char_valid(char_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] col;
    logic [9:0]  fila;
    logic [5:0]  code;
    logic        valid;
  } vec_t;

  vec_t vecs [14];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   rdy_seen  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Returns one time unit after the rising edge, where inputs are safe to change.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic blank(input int n);
    den_in = 1'b0;
    col_in = '0;
    repeat (n) tick();
  endtask

  // Slot cycle, two more pixels of the same cell, then sample where col_in[2:0]=2.
  task automatic fetch(input logic [10:0] col, input logic [9:0] fila);
    den_in  = 1'b1;
    fila_in = fila;
    col_in  = col;
    tick();
    col_in = col + 11'd1;
    tick();
    col_in = col + 11'd2;
    @(negedge CLK);
  endtask

  task automatic host_write(input string name, input logic [6:0] c, input logic [5:0] r,
                            input logic [5:0] ch, input logic exp_err);
    int waited = 0;
    // NOTE: bench stimulus uses blocking assignments away from the clock edge.
    host_if.wr_valid = 1'b1;
    host_if.wr_col   = c;
    host_if.wr_row   = r;
    host_if.wr_char  = ch;
    @(negedge CLK);
    while (!host_if.wr_ready && waited < 200) begin
      tick();
      @(negedge CLK);
      waited++;
    end
    check({name, " ready"}, 32'(host_if.wr_ready), 32'd1);
    tick();
    host_if.wr_valid = 1'b0;
    @(negedge CLK);
    check({name, " err"}, 32'(host_if.wr_err), 32'(exp_err));
    tick();
    @(negedge CLK);
    check({name, " err end"}, 32'(host_if.wr_err), 32'd0);
    tick();
  endtask

  // Counts sampled cycles with clr_busy high, starting from `start`, den_in left as set.
  task automatic count_busy(input int start, output int n);
    n = start;
    @(negedge CLK);
    while (host_if.clr_busy && n < 20000) begin
      if (host_if.wr_ready) rdy_seen++;
      n++;
      tick();
      @(negedge CLK);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy, ready_bad, free_busy, slots, cyc;
    logic [5:0] exp_code;

    vecs[0]  = '{11'd24,   10'd16,   6'o12, 1'b1};
    vecs[1]  = '{11'd32,   10'd16,   6'o00, 1'b1};
    vecs[2]  = '{11'd792,  10'd472,  6'o77, 1'b1};
    vecs[3]  = '{11'd0,    10'd0,    6'o05, 1'b1};
    vecs[4]  = '{11'd400,  10'd240,  6'o41, 1'b1};
    vecs[5]  = '{11'd784,  10'd479,  6'o33, 1'b1};
    vecs[6]  = '{11'd800,  10'd0,    6'o00, 1'b0};
    vecs[7]  = '{11'd792,  10'd0,    6'o00, 1'b1};
    vecs[8]  = '{11'd0,    10'd8,    6'o00, 1'b1};
    vecs[9]  = '{11'd0,    10'd480,  6'o00, 1'b0};
    vecs[10] = '{11'd2040, 10'd1016, 6'o00, 1'b0};
    vecs[11] = '{11'd24,   10'd23,   6'o12, 1'b1};
    vecs[12] = '{11'd24,   10'd8,    6'o00, 1'b1};
    vecs[13] = '{11'd0,    10'd472,  6'o00, 1'b1};

    RST = 1'b1; den_in = 1'b0; col_in = '0; fila_in = '0;
    host_if.wr_valid = 1'b0; host_if.wr_col = '0; host_if.wr_row = '0;
    host_if.wr_char = '0; host_if.clr_req = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    check("reset clr_busy", 32'(host_if.clr_busy), 32'd1);
    check("reset wr_ready", 32'(host_if.wr_ready), 32'd0);
    check("reset wr_err", 32'(host_if.wr_err), 32'd0);
    check("reset char_code", 32'(char_code), 32'd0);
    check("reset char_valid", 32'(char_valid), 32'd0);
    tick();
    RST = 1'b0;

    count_busy(0, n_busy);
    check("initial clear length", n_busy, CELLS);
    check("wr_ready during clear", rdy_seen, 0);
    check("idle wr_ready", 32'(host_if.wr_ready), 32'd1);
    tick();

    host_write("wr 3,2", 7'd3, 6'd2, 6'o12, 1'b0);
    host_write("wr 99,59", 7'd99, 6'd59, 6'o77, 1'b0);
    host_write("wr 0,0", 7'd0, 6'd0, 6'o05, 1'b0);
    host_write("wr 50,30", 7'd50, 6'd30, 6'o41, 1'b0);
    host_write("wr 98,59", 7'd98, 6'd59, 6'o33, 1'b0);
    host_write("wr col 100", 7'd100, 6'd0, 6'o55, 1'b1);
    host_write("wr row 60", 7'd0, 6'd60, 6'o44, 1'b1);

    foreach (vecs[i]) begin
      fetch(vecs[i].col, vecs[i].fila);
      check($sformatf("vec%0d code", i), 32'(char_code), 32'(vecs[i].code));
      check($sformatf("vec%0d valid", i), 32'(char_valid), 32'(vecs[i].valid));
      blank(2);
    end

    // Result appears at col_in=26, holds through 33, then the slot at 32 lands at 34.
    fetch(11'd32, 10'd16);
    blank(2);
    den_in = 1'b1; fila_in = 10'd16;
    for (int c = 24; c <= 34; c++) begin
      col_in = 11'(c);
      @(negedge CLK);
      exp_code = (c >= 26 && c <= 33) ? 6'o12 : 6'o00;
      check($sformatf("hold col %0d", c), 32'(char_code), 32'(exp_code));
      tick();
    end
    blank(2);

    ready_bad = 0;
    den_in = 1'b1; fila_in = 10'd0;
    host_if.wr_valid = 1'b1; host_if.wr_col = 7'd10; host_if.wr_row = 6'd0;
    host_if.wr_char = 6'o21;
    for (int c = 16; c < 40; c++) begin
      col_in = 11'(c);
      @(negedge CLK);
      if (host_if.wr_ready !== ((c % 8) != 0)) ready_bad++;
      tick();
    end
    host_if.wr_valid = 1'b0;
    check("stall wr_ready pattern", ready_bad, 0);
    blank(2);
    fetch(11'd80, 10'd0);
    check("stalled write readback", 32'(char_code), 32'o21);
    check("stalled write valid", 32'(char_valid), 32'd1);
    blank(2);

    host_if.wr_valid = 1'b1; host_if.wr_col = 7'd3; host_if.wr_row = 6'd2;
    host_if.wr_char = 6'o66; host_if.clr_req = 1'b1;
    @(negedge CLK);
    check("write+clr ready", 32'(host_if.wr_ready), 32'd1);
    tick();
    host_if.wr_valid = 1'b0; host_if.clr_req = 1'b0;
    free_busy = 0; slots = 0; cyc = 0; rdy_seen = 0;
    fila_in = 10'd16;
    while (cyc < 30000) begin
      col_in = 11'(cyc);
      den_in = (cyc % 64) < 40;
      host_if.clr_req = (cyc == 2500);
      @(negedge CLK);
      if (cyc == 0) check("clr starts", 32'(host_if.clr_busy), 32'd1);
      if (!host_if.clr_busy) break;
      if (host_if.wr_ready) rdy_seen++;
      if (den_in && (col_in[2:0] == 3'd0)) slots++;
      else free_busy++;
      tick();
      cyc++;
    end
    host_if.clr_req = 1'b0;
    check("clear free cycles", free_busy, CELLS);
    check("clear saw stalls", 32'(slots > 0), 32'd1);
    check("wr_ready during video clear", rdy_seen, 0);
    blank(2);
    fetch(11'd24, 10'd16);
    check("write overwritten by clear", 32'(char_code), 32'd0);
    blank(2);
    fetch(11'd0, 10'd0);
    check("cell 0,0 cleared", 32'(char_code), 32'd0);
    check("cell 0,0 valid", 32'(char_valid), 32'd1);
    blank(2);

    host_write("wr 5,0", 7'd5, 6'd0, 6'o17, 1'b0);
    fetch(11'd40, 10'd0);
    check("pre-reset code", 32'(char_code), 32'o17);
    blank(1);
    host_if.clr_req = 1'b1;
    tick();
    host_if.clr_req = 1'b0;
    repeat (3000) tick();
    RST = 1'b1;
    @(negedge CLK);
    check("wr_ready in reset", 32'(host_if.wr_ready), 32'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    check("mid reset clr_busy", 32'(host_if.clr_busy), 32'd1);
    check("mid reset char_code", 32'(char_code), 32'd0);
    check("mid reset char_valid", 32'(char_valid), 32'd0);
    check("mid reset wr_err", 32'(host_if.wr_err), 32'd0);
    check("mid reset wr_ready", 32'(host_if.wr_ready), 32'd0);
    tick();
    rdy_seen = 0;
    count_busy(1, n_busy);
    check("restarted clear length", n_busy, CELLS);
    check("wr_ready during restart", rdy_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
